bram_fifo_ctrl: RTL and testbench
=================================

# bram_fifo_ctrl

Stream-to-BRAM FIFO controller that owns both ports of the 1024×8 simple dual-port block RAM. Upstream, it accepts a valid/ready byte stream and drives BRAM port A writes. Downstream, it issues BRAM port B reads, absorbs the one-cycle read latency in a 2-entry output buffer, and presents a valid/ready stream. It sits directly in front of and behind the BRAM instance in the top level, replacing ad-hoc port driving.

## Interface
- `ADDR_W`, default 10: BRAM address width; depth = 2^ADDR_W.
- `DATA_W`, default 8: data width.

Ports:
- `clk`  in  1  single clock; drives both BRAM ports.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  upstream data valid.
- `s_ready`  out  1  FIFO can accept; `s_ready = (level != 2^ADDR_W)`.
- `s_data`  in  DATA_W  upstream byte.
- `m_valid`  out  1  output buffer head valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_W  output buffer head.
- `level`  out  ADDR_W+1  total entries held (BRAM + in-flight + output buffer).
- `bram_ena`, `bram_wea[0:0]`  out  1  port A enable and write enable.
- `bram_addra`  out  ADDR_W  write address.
- `bram_dina`  out  DATA_W  write data.
- `bram_enb`  out  1  port B enable.
- `bram_addrb`  out  ADDR_W  read address.
- `bram_doutb`  in  DATA_W  read data, valid one cycle after `bram_enb`.
- `err_ovf`, `err_udf`  out  1  sticky error flags; present only with `BRAM_FIFO_ERR_EN`.

## Operation
- Push = `s_valid & s_ready`. When push is true: `bram_ena = bram_wea = 1`, `bram_addra = wptr`, `bram_dina = s_data`, all combinational. `wptr` increments at the edge and wraps from 2^ADDR_W−1 to 0.
- `mem_cnt` counts entries written but not yet read-issued.
- Read issue happens when `mem_cnt != 0` and `(buf_cnt + inflight − pop) < 2`:
  - `bram_enb = 1`, `bram_addrb = rptr`.
  - `rptr` wraps.
  - `mem_cnt` decrements.
  - `inflight` is set for the next cycle.
- When `inflight` is set, `bram_doutb` is captured into the output buffer at that cycle's edge.
- Output buffer: 2-entry FIFO. The head drives `m_data`, and `m_valid = (buf_cnt != 0)`. Pop = `m_valid & m_ready`.
- `level` is +1 on push and −1 on pop. Both together leave it unchanged.
- `s_ready` has no combinational dependence on `m_ready`. When full, a same-cycle pop does not enable a push.
- Empty: `m_valid = 0`, `bram_enb = 0`, and `m_data` is held at its last value.
- Read-before-write hazard is impossible: a read is issued only against `mem_cnt`, which is updated one edge after the write.
- `m_data` is held stable while `m_valid & ~m_ready`.

## Timing
- Reset values:
  - `s_ready = 1`, `m_valid = 0`, `m_data = 0`, `level = 0`.
  - All BRAM enables are 0; addresses and `bram_dina` are 0.
  - `err_*` = 0.
  - Internally: `wptr = rptr = 0`, `mem_cnt = buf_cnt = inflight = 0`.
- Reset mid-operation clears all pointers and counts, drops in-flight reads and buffered data, and forces BRAM enables low immediately. BRAM contents are not cleared.
- Fall-through latency: a push accepted at edge E0 produces read issue in the cycle after E0, data capture at E2, and `m_valid = 1` after E2. That is 2 cycles from the accept edge.
- Throughput: with `s_valid` and `m_ready` held high, 1 byte/cycle in steady state.
- Full: `level == 2^ADDR_W` gives `s_ready = 0`. `s_ready` returns to 1 the cycle after the first pop.

## Configuration
- `BRAM_FIFO_ERR_EN` defined: `err_ovf` and `err_udf` are present.
  - `err_ovf` sets on `s_valid & ~s_ready`.
  - `err_udf` sets on `m_ready & ~m_valid` while `level == 0` and at least one push has occurred since reset.
  - Both are sticky until `rst`.
- Undefined: the ports and their logic are absent, and there is no other behavioural difference.

## Test plan
- Reset, then push bytes 0x11, 0x22, 0x33 with `m_ready = 0` → `level = 3`; `m_valid` rises 2 cycles after the first push; `m_data = 0x11` held stable.
- Push 1024 bytes 0x00..0xFF repeating with `m_ready = 0` → `level = 1024`, `s_ready = 0`. Then pulse `m_ready` for one cycle → `s_ready = 1` on the following cycle.
- Continuous push and pop of 3000 bytes with random `m_ready` (50%) → output sequence is identical, pointers wrap past 0x3FF, and no byte is lost or duplicated.
- Continuous `s_valid`/`m_ready` high → after the initial 2-cycle latency, one byte per cycle out; `level` stays constant.
- Assert `rst` with 5 bytes queued and a read in flight → the next cycle shows `m_valid = 0`, `level = 0`, `bram_enb = 0`. A new push of 0xA5 emerges first.
- With `BRAM_FIFO_ERR_EN`: push while full → `err_ovf = 1` and sticky. Without the macro: the same stimulus builds cleanly with no error ports present.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// bram_fifo_ctrl
//
// Purpose:
//   Stream-to-BRAM FIFO controller. It owns both ports of a simple dual-port
//   block RAM (depth 2^ADDR_W, width DATA_W):
//   - Port A is written from an upstream valid/ready byte stream.
//   - Port B is read into a 2-entry output buffer. The buffer absorbs the
//     one-cycle BRAM read latency and feeds a downstream valid/ready stream.
//
// Optional feature macro:
//   BRAM_FIFO_ERR_EN - adds the sticky error flags err_ovf / err_udf.
//
// Parameters:
//   ADDR_W      BRAM address width (depth = 2^ADDR_W), default 10
//   DATA_W      data width, default 8
//
// Ports:
//   clk         single clock for both BRAM ports
//   rst         asynchronous, active-high reset
//   s_valid     upstream data valid
//   s_ready     FIFO can accept (level != 2^ADDR_W)
//   s_data      upstream data
//   m_valid     output buffer head valid
//   m_ready     downstream accepts
//   m_data      output buffer head (held at last value when empty)
//   level       total entries held (BRAM + in-flight read + output buffer)
//   bram_ena    port A enable
//   bram_wea    port A write enable
//   bram_addra  port A write address
//   bram_dina   port A write data
//   bram_enb    port B enable (read issue)
//   bram_addrb  port B read address
//   bram_doutb  port B read data, valid one cycle after bram_enb
//   err_ovf     sticky: push attempted while full   (BRAM_FIFO_ERR_EN only)
//   err_udf     sticky: pop attempted while empty   (BRAM_FIFO_ERR_EN only)
// ---------------------------------------------------------------------------
module bram_fifo_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W:0]   level,
    output logic              bram_ena,
    output logic [0:0]        bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    output logic              bram_enb,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [DATA_W-1:0] bram_doutb
`ifdef BRAM_FIFO_ERR_EN
    ,
    output logic              err_ovf,
    output logic              err_udf
`endif
);

    // Level value meaning "every BRAM location is occupied".
    localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_mem_cnt;   // written but not yet read-issued
    logic              r_inflight;  // read issued last cycle, data on doutb now
    logic [ADDR_W:0]   r_level;
    logic [DATA_W-1:0] r_buf0;      // output buffer head
    logic [DATA_W-1:0] r_buf1;      // output buffer second entry
    logic [1:0]        r_buf_cnt;

    // -----------------------------------------------------------------------
    // Handshakes and read-issue decision
    // -----------------------------------------------------------------------
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_committed;  // buffer slots claimed after this edge
    logic [1:0]        w_cap_slot;   // slot the in-flight byte lands in

    assign s_ready = (r_level != FULL_LEVEL);
    assign m_valid = (r_buf_cnt != 2'd0);
    assign m_data  = r_buf0;
    assign level   = r_level;

    // Reset gates the handshakes so both BRAM enables drop the moment reset
    // asserts, even with s_valid held high.
    assign w_push = s_valid & s_ready & ~rst;
    assign w_pop  = m_valid & m_ready;

    // Slots occupied or reserved once this cycle's pop has left. A new read
    // may only be issued if its data is guaranteed a slot on arrival.
    assign w_committed = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_mem_cnt != '0) & (w_committed < 3'd2) & ~rst;

    // After the pop leaves, the arriving byte goes behind whatever remains.
    assign w_cap_slot  = r_buf_cnt - {1'b0, w_pop};

    // -----------------------------------------------------------------------
    // BRAM port drive (combinational)
    // -----------------------------------------------------------------------
    assign bram_ena    = w_push;
    assign bram_wea    = w_push;
    assign bram_addra  = r_wptr;
    assign bram_dina   = w_push ? s_data : '0;
    assign bram_enb    = w_issue;
    assign bram_addrb  = r_rptr;

    // -----------------------------------------------------------------------
    // Pointers, BRAM occupancy, in-flight flag and total level
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_level    <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_issue) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end

            case ({w_push, w_issue})
                2'b10:   r_mem_cnt <= r_mem_cnt + (ADDR_W+1)'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - (ADDR_W+1)'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase

            r_inflight <= w_issue;

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer: 2-entry shift FIFO with the head fixed in r_buf0.
    // Popping the last entry without a replacement leaves r_buf0 untouched,
    // which keeps m_data at its last value while empty.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf0    <= '0;
            r_buf1    <= '0;
            r_buf_cnt <= 2'd0;
        end else begin
            if (w_pop && (r_buf_cnt == 2'd2)) begin
                r_buf0 <= r_buf1;
            end
            if (r_inflight) begin
                if (w_cap_slot == 2'd0) begin
                    r_buf0 <= bram_doutb;
                end else begin
                    r_buf1 <= bram_doutb;
                end
            end
            r_buf_cnt <= r_buf_cnt - {1'b0, w_pop} + {1'b0, r_inflight};
        end
    end

`ifdef BRAM_FIFO_ERR_EN
    // -----------------------------------------------------------------------
    // Sticky error flags. Underflow is only meaningful once the FIFO has been
    // used, so an idle m_ready straight out of reset is not flagged.
    // -----------------------------------------------------------------------
    logic r_pushed_any;
    logic r_err_ovf;
    logic r_err_udf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pushed_any <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_udf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_pushed_any <= 1'b1;
            end
            if (s_valid && !s_ready) begin
                r_err_ovf <= 1'b1;
            end
            if (m_ready && !m_valid && (r_level == '0) && r_pushed_any) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for bram_fifo_ctrl.
//
// The environment includes a behavioural 1024x8 simple dual-port BRAM model
// with one-cycle read latency. A negedge monitor keeps a reference queue of
// accepted bytes. It compares every output handshake, the level count, the
// ready state and the BRAM addresses against that queue. Directed sequences
// check latency, the full condition, throughput and reset behaviour.
// ---------------------------------------------------------------------------
module tb_bram_fifo_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW:0]   level;
    logic          bram_ena;
    logic [0:0]    bram_wea;
    logic [AW-1:0] bram_addra;
    logic [DW-1:0] bram_dina;
    logic          bram_enb;
    logic [AW-1:0] bram_addrb;
    logic [DW-1:0] bram_doutb;
`ifdef BRAM_FIFO_ERR_EN
    logic          err_ovf;
    logic          err_udf;
`endif

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_enb   (bram_enb),
        .bram_addrb (bram_addrb),
        .bram_doutb (bram_doutb)
`ifdef BRAM_FIFO_ERR_EN
        ,
        .err_ovf    (err_ovf),
        .err_udf    (err_udf)
`endif
    );

    // Behavioural BRAM: contents survive reset, read data one cycle late.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bram_ena && bram_wea[0]) mem[bram_addra] <= bram_dina;
        if (bram_enb) bram_doutb <= mem[bram_addrb];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Scoreboard monitor (negedge, away from the active edge)
    // -----------------------------------------------------------------------
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_b;
    logic [DW-1:0] prev_data = '0;
    bit            prev_hold = 1'b0;
    int            n_acc  = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            wr_cnt    = 0;
            rd_cnt    = 0;
            prev_hold = 1'b0;
        end else begin
            chk("level", 32'(level), 32'(sb.size()));
            chk("s_ready", 32'(s_ready), 32'(sb.size() != DEPTH));
            if (sb.size() == 0) chk("m_valid_empty", 32'(m_valid), 32'd0);
            if (prev_hold) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (bram_enb) begin
                chk("addrb", 32'(bram_addrb), 32'(rd_cnt % DEPTH));
                rd_cnt++;
            end
            if (m_valid && m_ready && sb.size() != 0) begin
                exp_b = sb.pop_front();
                chk("m_data", 32'(m_data), 32'(exp_b));
            end
            if (s_valid && s_ready) begin
                chk("ena", 32'({bram_ena, bram_wea}), 32'd3);
                chk("addra", 32'(bram_addra), 32'(wr_cnt % DEPTH));
                chk("dina", 32'(bram_dina), 32'(s_data));
                sb.push_back(s_data);
                wr_cnt++;
                n_acc++;
            end else begin
                chk("ena_idle", 32'(bram_ena), 32'd0);
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int c;
        c       = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while (level != '0 && c < bound) begin
            step();
            c++;
        end
        chk("drain_done", 32'(level), 32'd0);
        step();
    endtask

    initial begin
        int target;
        int c;

        // Reset values
        repeat (3) step();
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_enables", 32'({bram_ena, bram_wea, bram_enb}), 32'd0);
        chk("rst_addr", 32'({bram_addra, bram_addrb, bram_dina}), 32'd0);
`ifdef BRAM_FIFO_ERR_EN
        chk("rst_err", 32'({err_ovf, err_udf}), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Fall-through latency and hold with m_ready low
        s_valid = 1'b1; s_data = 8'h11;
        step();
        chk("lat_e0", 32'(m_valid), 32'd0);
        s_data = 8'h22;
        step();
        chk("lat_e1", 32'(m_valid), 32'd0);
        s_data = 8'h33;
        step();
        chk("lat_e2", 32'(m_valid), 32'd1);
        chk("lat_data", 32'(m_data), 32'h11);
        s_valid = 1'b0;
        repeat (3) step();
        chk("t1_level", 32'(level), 32'd3);
        chk("t1_head", 32'(m_data), 32'h11);
`ifdef BRAM_FIFO_ERR_EN
        chk("t1_udf_clear", 32'(err_udf), 32'd0);
`endif
        drain(20);

        // Fill to full, try to overflow, then one pop
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_data = 8'(i);
            step();
        end
        chk("full_level", 32'(level), 32'(DEPTH));
        chk("full_s_ready", 32'(s_ready), 32'd0);
        s_data = 8'hEE;
        repeat (2) step();
        chk("ovf_level", 32'(level), 32'(DEPTH));
        s_valid = 1'b0;
        step();
`ifdef BRAM_FIFO_ERR_EN
        chk("err_ovf", 32'(err_ovf), 32'd1);
`endif
        m_ready = 1'b1;
        #3;
        chk("s_ready_no_comb", 32'(s_ready), 32'd0);
        step();
        m_ready = 1'b0;
        chk("s_ready_after_pop", 32'(s_ready), 32'd1);
        chk("level_after_pop", 32'(level), 32'(DEPTH - 1));
        drain(3000);
`ifdef BRAM_FIFO_ERR_EN
        repeat (2) step();
        chk("err_udf", 32'(err_udf), 32'd1);
        chk("err_ovf_sticky", 32'(err_ovf), 32'd1);
`endif

        // Random stream: continuous push, 50% m_ready, pointers wrap
        target = n_acc + 3000;
        c = 0;
        s_valid = 1'b1;
        while (n_acc < target && c < 20000) begin
            s_data  = 8'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            step();
            c++;
        end
        chk("rand_accepted", 32'(n_acc), 32'(target));
        drain(3000);

        // Throughput: both sides held high
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            s_data = 8'($urandom);
            step();
            if (cyc == 2) chk("tp_latency", 32'(m_valid), 32'd0);
            if (cyc >= 3) begin
                chk("tp_valid", 32'(m_valid), 32'd1);
                chk("tp_level", 32'(level), 32'd3);
            end
        end
        drain(20);

        // Reset mid-operation with a read in flight
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 8'($urandom);
            step();
        end
        s_valid = 1'b0;
        repeat (2) step();
        m_ready = 1'b1;
        step();
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h5A;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_enb", 32'(bram_enb), 32'd0);
        chk("mid_rst_ena", 32'(bram_ena), 32'd0);
        step();
        chk("mid_rst_next", 32'({m_valid, bram_enb}), 32'd0);
        step();
        rst = 1'b0;
        m_ready = 1'b0;
        s_data = 8'hA5;
        step();
        s_valid = 1'b0;
        c = 0;
        while (!m_valid && c < 10) begin
            step();
            c++;
        end
        chk("post_rst_valid", 32'(m_valid), 32'd1);
        chk("post_rst_first", 32'(m_data), 32'hA5);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
